// File: rtl/sr_ctrl_pkg.sv
// Shared definitions for the SR latch bank controller.
// Holds the sequencing state encoding, the op constants and a width helper.
package sr_ctrl_pkg;

   // Sequencer states: arbitrate, pulse enable, hold s/r, acknowledge.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRIVE = 2'd1,
      HOLD  = 2'd2,
      DONE  = 2'd3
   } state_t;

   // Requester op encoding on req_op.
   localparam logic OP_SET = 1'b1;
   localparam logic OP_CLR = 1'b0;

   // Width of an index able to address n items. Never returns 0, so
   // single-entry configurations still get a legal one-bit vector.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/sr_latch_bank_arbiter_rr_arbiter.sv
// Combinational round-robin picker.
// Searches req upward from ptr with wrap-around and returns the first hit as
// both a one-hot vector and a binary index. The pointer register itself is
// owned by the parent so it can be advanced only when a grant is accepted.
module rr_arbiter #(
   parameter int  N = 4,
   localparam int W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] ptr,
   output logic [N-1:0] grant,
   output logic [W-1:0] grant_idx
);

   // Walk the N positions starting at ptr; the first requester found wins.
   always_comb begin
      int   pos;
      logic found;
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      pos       = 0;
      for (int k = 0; k < N; k++) begin
         pos = (int'(ptr) + k) % N;
         if (!found && req[pos]) begin
            found      = 1'b1;
            grant[pos] = 1'b1;
            grant_idx  = W'(pos);
         end
      end
   end

endmodule

// File: rtl/sr_latch_bank_arbiter.sv
// SR latch bank arbiter.
// NUM_REQ requesters share a bank of enable-gated SR latches. One request at a
// time is granted round-robin, then the sequencer drives s/r with an enable
// pulse of PULSE_CYC cycles, keeps s/r for one more cycle after enable falls,
// releases s/r and pulses ack to the granted requester.
// s and r are derived from a single captured op bit, so they can never be
// high together on any latch.
// Optional feature macro: SR_VERIFY_EN (read back latch_q in DONE, sticky err).
module sr_latch_bank_arbiter
   import sr_ctrl_pkg::*;
#(
   parameter int  NUM_REQ   = 4,
   parameter int  NUM_LATCH = 8,
   parameter int  PULSE_CYC = 2,
   localparam int IDXW      = idx_width(NUM_LATCH),
   localparam int GW        = idx_width(NUM_REQ)
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic [NUM_REQ-1:0]      req,
   input  logic [NUM_REQ-1:0]      req_op,
   input  logic [NUM_REQ*IDXW-1:0] req_idx,
   output logic [NUM_REQ-1:0]      ack,
   output logic [GW-1:0]           grant_id,
   output logic                    busy,
   output logic [NUM_LATCH-1:0]    latch_s,
   output logic [NUM_LATCH-1:0]    latch_r,
   output logic [NUM_LATCH-1:0]    latch_en,
   input  logic [NUM_LATCH-1:0]    latch_q,
   output logic                    err
);

   localparam int CW = idx_width(PULSE_CYC);

   // ------------------------------------------------------------------
   // State and captured-request registers
   // ------------------------------------------------------------------
   state_t              state_reg, state_next;
   logic [CW-1:0]       cnt_reg, cnt_next;
   logic [GW-1:0]       ptr_reg, ptr_next;
   logic                op_reg, op_next;
   logic [IDXW-1:0]     idx_reg, idx_next;
   logic [GW-1:0]       grant_id_reg, grant_id_next;

   // Registered outputs and their next values
   logic [NUM_REQ-1:0]   ack_reg, ack_next;
   logic                 busy_reg, busy_next;
   logic [NUM_LATCH-1:0] s_reg, s_next;
   logic [NUM_LATCH-1:0] r_reg, r_next;
   logic [NUM_LATCH-1:0] en_reg, en_next;

   // Arbitration results and per-requester fields
   logic [NUM_REQ-1:0]   arb_grant;
   logic [GW-1:0]        arb_idx;
   logic [IDXW-1:0]      idx_arr [NUM_REQ];
   logic                 pick_op;
   logic [IDXW-1:0]      pick_idx;

   // Decoded selects: latch addressed by the next captured index, and
   // requester addressed by the next grant id.
   logic [NUM_LATCH-1:0] sel_next;
   logic [NUM_REQ-1:0]   gid_hot;

   // ------------------------------------------------------------------
   // Request unpacking and decoders
   // ------------------------------------------------------------------
   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req_unpack
      assign idx_arr[gi] = req_idx[gi*IDXW +: IDXW];
   end

   // An index at or above NUM_LATCH matches no bit, so no latch line is
   // driven for it while the sequence itself still runs to ack.
   for (genvar gi = 0; gi < NUM_LATCH; gi++) begin : g_sel_dec
      assign sel_next[gi] = (idx_next == IDXW'(gi));
   end

   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_gid_dec
      assign gid_hot[gi] = (grant_id_next == GW'(gi));
   end

   rr_arbiter #(
      .N(NUM_REQ)
   ) u_rr_arbiter (
      .req      (req),
      .ptr      (ptr_reg),
      .grant    (arb_grant),
      .grant_idx(arb_idx)
   );

   // Mux the winning requester's op and index using the one-hot grant.
   always_comb begin
      pick_op  = |(arb_grant & req_op);
      pick_idx = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (arb_grant[k]) begin
            pick_idx = idx_arr[k];
         end
      end
   end

   // ------------------------------------------------------------------
   // Next-state logic: arbitration, pulse counting, captured fields
   // ------------------------------------------------------------------
   // Sequence IDLE -> DRIVE (PULSE_CYC cycles) -> HOLD -> DONE -> IDLE.
   always_comb begin
      state_next    = state_reg;
      cnt_next      = cnt_reg;
      ptr_next      = ptr_reg;
      op_next       = op_reg;
      idx_next      = idx_reg;
      grant_id_next = grant_id_reg;
      case (state_reg)
         IDLE: begin
            if (|req) begin
               state_next    = DRIVE;
               cnt_next      = '0;
               op_next       = pick_op;
               idx_next      = pick_idx;
               grant_id_next = arb_idx;
               // Start the next search just past the winner.
               ptr_next      = (arb_idx == GW'(NUM_REQ - 1)) ? '0 : arb_idx + GW'(1);
            end
         end
         DRIVE: begin
            if (cnt_reg == CW'(PULSE_CYC - 1)) begin
               state_next = HOLD;
            end else begin
               cnt_next = cnt_reg + CW'(1);
            end
         end
         HOLD: begin
            state_next = DONE;
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Output decode, computed from the upcoming state so every output is
   // a plain register with no combinational path to the ports.
   // ------------------------------------------------------------------
   // Enable only in DRIVE, s/r in DRIVE and HOLD, ack only in DONE.
   always_comb begin
      ack_next  = '0;
      busy_next = (state_next != IDLE);
      en_next   = '0;
      s_next    = '0;
      r_next    = '0;
      case (state_next)
         DRIVE: begin
            en_next = sel_next;
            s_next  = (op_next == OP_SET) ? sel_next : '0;
            r_next  = (op_next == OP_CLR) ? sel_next : '0;
         end
         HOLD: begin
            s_next  = (op_next == OP_SET) ? sel_next : '0;
            r_next  = (op_next == OP_CLR) ? sel_next : '0;
         end
         DONE: begin
            ack_next = gid_hot;
         end
         default: begin
         end
      endcase
   end

   // State, pointer, captured request and output registers.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_reg    <= IDLE;
         cnt_reg      <= '0;
         ptr_reg      <= '0;
         op_reg       <= OP_CLR;
         idx_reg      <= '0;
         grant_id_reg <= '0;
         ack_reg      <= '0;
         busy_reg     <= 1'b0;
         s_reg        <= '0;
         r_reg        <= '0;
         en_reg       <= '0;
      end else begin
         state_reg    <= state_next;
         cnt_reg      <= cnt_next;
         ptr_reg      <= ptr_next;
         op_reg       <= op_next;
         idx_reg      <= idx_next;
         grant_id_reg <= grant_id_next;
         ack_reg      <= ack_next;
         busy_reg     <= busy_next;
         s_reg        <= s_next;
         r_reg        <= r_next;
         en_reg       <= en_next;
      end
   end

   // ------------------------------------------------------------------
   // Optional readback check
   // ------------------------------------------------------------------
`ifdef SR_VERIFY_EN
   logic [NUM_LATCH-1:0] sel_cur;
   logic                 err_reg, err_next;

   for (genvar gi = 0; gi < NUM_LATCH; gi++) begin : g_sel_cur
      assign sel_cur[gi] = (idx_reg == IDXW'(gi));
   end

   // In DONE the latch has had the full pulse plus hold, so its q must
   // equal the captured op; an index outside the bank is also an error.
   always_comb begin
      err_next = err_reg;
      if (state_reg == DONE) begin
         if (!(|sel_cur) || ((|(sel_cur & latch_q)) != op_reg)) begin
            err_next = 1'b1;
         end
      end
   end

   // Sticky error flag, cleared only by reset.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         err_reg <= 1'b0;
      end else begin
         err_reg <= err_next;
      end
   end

   assign err = err_reg;
`else
   // Readback disabled: latch_q is intentionally not observed.
   logic unused_latch_q;
   assign unused_latch_q = ^latch_q;
   assign err            = 1'b0;
`endif

   assign ack      = ack_reg;
   assign grant_id = grant_id_reg;
   assign busy     = busy_reg;
   assign latch_s  = s_reg;
   assign latch_r  = r_reg;
   assign latch_en = en_reg;

endmodule

// File: tb/tb_sr_latch_bank_arbiter.sv
// Self-checking bench for sr_latch_bank_arbiter (NUM_REQ=4, NUM_LATCH=8,
// PULSE_CYC=2) plus a NUM_LATCH=6 instance for out-of-range indices.
// Expected grants are queued when requests are raised and popped on ack.
// Build with SR_VERIFY_EN defined to exercise the readback error flag.
module tb_sr_latch_bank_arbiter;

   localparam int NR   = 4;
   localparam int NL   = 8;
   localparam int NL2  = 6;
   localparam int PC   = 2;
   localparam int IDXW = 3;

   logic clk     = 1'b0;
   logic reset_n = 1'b0;

   // Main DUT
   logic [NR-1:0]      req     = '0;
   logic [NR-1:0]      req_op  = '0;
   logic [NR*IDXW-1:0] req_idx = '0;
   logic [NR-1:0]      ack;
   logic [1:0]         grant_id;
   logic               busy;
   logic [NL-1:0]      latch_s, latch_r, latch_en, latch_q;
   logic               err;

   // Small-bank DUT
   logic [NR-1:0]      d2_req     = '0;
   logic [NR-1:0]      d2_req_op  = '0;
   logic [NR*IDXW-1:0] d2_req_idx = '0;
   logic [NR-1:0]      d2_ack;
   logic [1:0]         d2_grant_id;
   logic               d2_busy;
   logic [NL2-1:0]     d2_latch_s, d2_latch_r, d2_latch_en;
   logic [NL2-1:0]     d2_latch_q = '0;
   logic               d2_err;

   // Latch bank model with an override used to fake a stuck latch
   logic [NL-1:0] bank_q     = '0;
   logic [NL-1:0] force_mask = '0;
   logic [NL-1:0] force_val  = '0;

   int tests_run = 0;
   int fails     = 0;
   int acks      = 0;
   int cyc       = 0;
   int ptr_model = 0;

   logic op_tab  [NR];
   int   idx_tab [NR];

   typedef struct {
      int   id;
      logic op;
      int   idx;
      bit   chk_q;
   } exp_t;

   exp_t sb[$];
   int   ack_cycles[$];

   always #5 clk = ~clk;

   sr_latch_bank_arbiter #(.NUM_REQ(NR), .NUM_LATCH(NL), .PULSE_CYC(PC)) dut (
      .clk(clk), .reset_n(reset_n), .req(req), .req_op(req_op), .req_idx(req_idx),
      .ack(ack), .grant_id(grant_id), .busy(busy), .latch_s(latch_s),
      .latch_r(latch_r), .latch_en(latch_en), .latch_q(latch_q), .err(err)
   );

   sr_latch_bank_arbiter #(.NUM_REQ(NR), .NUM_LATCH(NL2), .PULSE_CYC(PC)) dut2 (
      .clk(clk), .reset_n(reset_n), .req(d2_req), .req_op(d2_req_op), .req_idx(d2_req_idx),
      .ack(d2_ack), .grant_id(d2_grant_id), .busy(d2_busy), .latch_s(d2_latch_s),
      .latch_r(d2_latch_r), .latch_en(d2_latch_en), .latch_q(d2_latch_q), .err(d2_err)
   );

   // Enable-gated SR latch behaviour, evaluated once per cycle.
   always @(posedge clk) begin
      for (int i = 0; i < NL; i++) begin
         if (latch_en[i]) begin
            if (latch_s[i])      bank_q[i] <= 1'b1;
            else if (latch_r[i]) bank_q[i] <= 1'b0;
         end
      end
   end

   assign latch_q = (bank_q & ~force_mask) | (force_val & force_mask);

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
      tests_run++;
      if (act !== exp_v) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp_v, cyc);
      end
   endtask

   // Per-cycle monitor: s/r exclusion, single enable, scoreboard on ack.
   task automatic mon();
      exp_t e;
      chk("sr_exclusive", 32'(latch_s & latch_r), 0);
      chk("en_at_most_one", 32'($countones(latch_en) <= 1), 1);
      if (ack != '0) begin
         ack_cycles.push_back(cyc);
         if (sb.size() == 0) begin
            chk("unexpected_ack", 32'(ack), 0);
         end else begin
            e = sb.pop_front();
            chk("ack_vector", 32'(ack), 32'(1) << e.id);
            chk("grant_id", 32'(grant_id), 32'(e.id));
            if (e.chk_q) chk("latch_q_after_op", 32'(bank_q[e.idx]), 32'(e.op));
            req[e.id] = 1'b0;
            acks++;
            $display("[TB] txn %0d: requester %0d %s latch %0d acked at cycle %0d",
                     acks, e.id, e.op ? "set" : "clear", e.idx, cyc);
         end
      end
   endtask

   task automatic tick();
      @(negedge clk);
      cyc++;
      mon();
   endtask

   task automatic set_req(input int id, input logic op, input int idx);
      op_tab[id]  = op;
      idx_tab[id] = idx;
   endtask

   // Raise a group of requests together; the expected service order is the
   // round-robin walk from the modelled pointer over the raised bits.
   task automatic launch(input logic [NR-1:0] mask, input bit chkq);
      exp_t e;
      int   last;
      last = ptr_model;
      for (int i = 0; i < NR; i++) begin
         if (mask[i]) begin
            req_op[i] = op_tab[i];
            req_idx[i*IDXW +: IDXW] = IDXW'(idx_tab[i]);
         end
      end
      for (int j = 0; j < NR; j++) begin
         int id;
         id = (ptr_model + j) % NR;
         if (mask[id]) begin
            e.id    = id;
            e.op    = op_tab[id];
            e.idx   = idx_tab[id];
            e.chk_q = chkq;
            sb.push_back(e);
            last = id;
         end
      end
      ptr_model = (last + 1) % NR;
      req = req | mask;
   endtask

   task automatic wait_acks(input int target, input int budget);
      int n;
      n = 0;
      while (acks < target && n < budget) begin
         tick();
         n++;
      end
      chk("ack_timeout", 32'(acks), 32'(target));
   endtask

   initial begin
      #100000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int en_cnt, s_cnt, r_seen, other_en, ack_at, busy1, busy5, base, n;
      bit hold_seen, found;
      int lines, d2_acks, d2_ack_at;

      // Reset state
      repeat (3) tick();
      chk("rst_ack", 32'(ack), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_grant_id", 32'(grant_id), 0);
      chk("rst_latch_en", 32'(latch_en), 0);
      chk("rst_latch_s", 32'(latch_s), 0);
      chk("rst_latch_r", 32'(latch_r), 0);
      chk("rst_err", 32'(err), 0);
      reset_n = 1'b1;
      tick();

      // 1: single set of latch 3, cycle-accurate shape
      set_req(0, 1'b1, 3);
      launch(4'b0001, 1'b1);
      en_cnt = 0; s_cnt = 0; r_seen = 0; other_en = 0; ack_at = 0; busy1 = 0; busy5 = 1;
      for (int t = 1; t <= 6; t++) begin
         tick();
         if (latch_en[3]) en_cnt++;
         if (latch_s[3]) s_cnt++;
         if (latch_r != '0) r_seen++;
         if ((latch_en & 8'hF7) != '0) other_en++;
         if (ack[0]) ack_at = t;
         if (t == 1) busy1 = int'(busy);
         if (t == 5) busy5 = int'(busy);
      end
      chk("t1_en_cycles", 32'(en_cnt), PC);
      chk("t1_s_cycles", 32'(s_cnt), PC + 1);
      chk("t1_r_never", 32'(r_seen), 0);
      chk("t1_other_en", 32'(other_en), 0);
      chk("t1_ack_latency", 32'(ack_at), PC + 2);
      chk("t1_busy_in_op", 32'(busy1), 1);
      chk("t1_busy_after", 32'(busy5), 0);

      // 2: all four hold their requests; strict rotation and spacing
      for (int i = 0; i < NR; i++) set_req(i, i[0], i);
      ack_cycles.delete();
      base = acks;
      launch(4'b1111, 1'b1);
      wait_acks(base + 4, 40);
      for (int k = 1; k < 4; k++)
         chk("b2b_period", 32'(ack_cycles[k] - ack_cycles[k-1]), PC + 3);
      set_req(0, 1'b1, 5); set_req(1, 1'b1, 6); set_req(3, 1'b0, 5);
      base = acks;
      launch(4'b1011, 1'b1);
      wait_acks(base + 3, 40);
      set_req(2, 1'b1, 1);
      base = acks;
      launch(4'b0100, 1'b1);
      wait_acks(base + 1, 20);
      set_req(0, 1'b0, 1); set_req(1, 1'b1, 0); set_req(2, 1'b0, 0); set_req(3, 1'b1, 2);
      base = acks;
      launch(4'b1111, 1'b1);
      wait_acks(base + 4, 40);

      // 3: set and clear of the same latch competing
      set_req(1, 1'b1, 7); set_req(2, 1'b0, 7);
      base = acks;
      launch(4'b0110, 1'b1);
      wait_acks(base + 2, 30);
      chk("t3_final_q7", 32'(bank_q[7]), 0);

      // 6: requester drops req during HOLD
      set_req(1, 1'b1, 4);
      base = acks;
      launch(4'b0010, 1'b1);
      hold_seen = 1'b0;
      n = 0;
      while (acks < base + 1 && n < 12) begin
         tick();
         n++;
         if (!hold_seen && busy && latch_en == '0 && latch_s[4]) begin
            req[1] = 1'b0;
            hold_seen = 1'b1;
         end
      end
      chk("t6_hold_seen", 32'(hold_seen), 1);
      wait_acks(base + 1, 10);
      repeat (4) tick();
      chk("t6_idle", 32'(busy), 0);
      chk("t6_sb_empty", 32'(sb.size()), 0);

`ifdef SR_VERIFY_EN
      // 5: readback mismatch sets a sticky err
      chk("t5_err_before", 32'(err), 0);
      force_mask = 8'h20;
      force_val  = 8'h00;
      set_req(0, 1'b1, 5);
      base = acks;
      launch(4'b0001, 1'b0);
      wait_acks(base + 1, 20);
      tick();
      chk("t5_err_set", 32'(err), 1);
      force_mask = '0;
      set_req(3, 1'b0, 5);
      base = acks;
      launch(4'b1000, 1'b1);
      wait_acks(base + 1, 20);
      tick();
      chk("t5_err_sticky", 32'(err), 1);
`else
      chk("err_tied_low", 32'(err), 0);
`endif

      // 4: reset during DRIVE aborts and clears the pointer
      req_op[1] = 1'b1;
      req_idx[1*IDXW +: IDXW] = 3'd2;
      req[1] = 1'b1;
      found = 1'b0;
      for (int t = 0; t < 6 && !found; t++) begin
         tick();
         if (latch_en != '0) found = 1'b1;
      end
      chk("t4_drive_seen", 32'(found), 1);
      reset_n = 1'b0;
      req[1]  = 1'b0;
      tick();
      chk("t4_en_cleared", 32'(latch_en), 0);
      chk("t4_s_cleared", 32'(latch_s), 0);
      chk("t4_r_cleared", 32'(latch_r), 0);
      chk("t4_busy_cleared", 32'(busy), 0);
      chk("t4_ack_none", 32'(ack), 0);
      chk("t4_grant_id", 32'(grant_id), 0);
      chk("t4_err_cleared", 32'(err), 0);
      reset_n   = 1'b1;
      ptr_model = 0;
      repeat (3) tick();
      chk("t4_idle_after", 32'(busy), 0);
      set_req(1, 1'b0, 6); set_req(3, 1'b1, 0);
      base = acks;
      launch(4'b1010, 1'b1);
      wait_acks(base + 2, 30);

      // Out-of-range index on a 6-latch bank: no lines, ack still pulses
      d2_req_op[0] = 1'b1;
      d2_req_idx[0 +: IDXW] = 3'd6;
      d2_req[0] = 1'b1;
      lines = 0; d2_acks = 0; d2_ack_at = 0;
      for (int t = 1; t <= 8; t++) begin
         tick();
         if ((d2_latch_en | d2_latch_s | d2_latch_r) != '0) lines++;
         if (d2_ack[0]) begin
            d2_acks++;
            d2_ack_at = t;
            d2_req[0] = 1'b0;
         end
      end
      $display("[TB] txn oob: small bank requester 0 set latch 6 acked %0d time(s)", d2_acks);
      chk("oob_no_lines", 32'(lines), 0);
      chk("oob_ack_count", 32'(d2_acks), 1);
      chk("oob_ack_latency", 32'(d2_ack_at), PC + 2);
      chk("oob_idle", 32'(d2_busy), 0);
`ifdef SR_VERIFY_EN
      chk("oob_err", 32'(d2_err), 1);
`else
      chk("oob_err", 32'(d2_err), 0);
`endif

      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end

endmodule
